// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared types and helpers for the NCO sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    typedef enum logic [1:0] {
        SINGLE   = 2'd0,
        SAWTOOTH = 2'd1,
        TRIANGLE = 2'd2
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // Largest magnitude the NCO accepts symmetrically: 2^(width-1)-1.
    function automatic int sat_limit(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // The reserved encoding behaves as a one-shot sweep.
    function automatic sweep_mode_t decode_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return SAWTOOTH;
            2'd2:    return TRIANGLE;
            default: return SINGLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : nco_dwell_timer
// Description : Loadable down-counter that flags expiry when it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [DWELL_WIDTH-1:0] value_i,
    output logic                   expire_o
);

    logic [DWELL_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_WIDTH'(1);
        end
    end

    assign expire_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Steps the NCO delta-phase from start to stop with a per-value
//               dwell; supports single, sawtooth and triangle sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int DELTA_PHASE_WIDTH = 10,
    parameter int DWELL_WIDTH       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic signed [DELTA_PHASE_WIDTH-1:0] cfg_start_i,
    input  logic signed [DELTA_PHASE_WIDTH-1:0] cfg_stop_i,
    input  logic        [DELTA_PHASE_WIDTH-2:0] cfg_step_i,
    input  logic        [DWELL_WIDTH-1:0]       cfg_dwell_i,
    input  logic        [1:0]                   cfg_mode_i,
    input  logic                                abort_i,
    output logic signed [DELTA_PHASE_WIDTH-1:0] delta_phase_o,
    output logic                                step_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int c_dpw = DELTA_PHASE_WIDTH;
    localparam logic signed [c_dpw-1:0] c_most_neg = {1'b1, {(c_dpw-1){1'b0}}};
    localparam logic signed [c_dpw-1:0] c_sat_neg  = c_dpw'(-sat_limit(c_dpw));
    localparam logic        [c_dpw-2:0] c_step_one = {{(c_dpw-2){1'b0}}, 1'b1};

    sweep_state_t r_state, w_state_next;

    // Latched descriptor
    logic signed [c_dpw-1:0] r_start, r_stop, r_target;
    logic        [c_dpw-2:0] r_step;
    logic  [DWELL_WIDTH-1:0] r_dwell;
    sweep_mode_t             r_mode;
    logic                    r_dir_up;
    logic                    r_to_stop;

    // Registered outputs
    logic signed [c_dpw-1:0] r_delta;
    logic                    r_ready, r_step_strobe, r_busy, r_done;

    logic signed [c_dpw-1:0] w_delta_next;
    logic                    w_step_next, w_done_next;
    logic                    w_accept, w_reverse;
    logic                    w_timer_load, w_expire;
    logic  [DWELL_WIDTH-1:0] w_timer_value;
    logic signed [c_dpw-1:0] w_start_sat, w_stop_sat, w_rev_target;
    logic        [c_dpw-2:0] w_step_eff;

    // -2^(W-1) has no positive counterpart, so fold it onto the symmetric range.
    assign w_start_sat  = (cfg_start_i == c_most_neg) ? c_sat_neg : cfg_start_i;
    assign w_stop_sat   = (cfg_stop_i  == c_most_neg) ? c_sat_neg : cfg_stop_i;
    assign w_step_eff   = (cfg_step_i == '0) ? c_step_one : cfg_step_i;
    assign w_rev_target = r_to_stop ? r_start : r_stop;

    // One step toward tgt, clamped so the target is never overshot.
    function automatic logic signed [c_dpw-1:0] f_advance(
        input logic signed [c_dpw-1:0] cur,
        input logic signed [c_dpw-1:0] tgt,
        input logic                    up,
        input logic        [c_dpw-2:0] mag
    );
        logic signed [c_dpw:0] cur_x, tgt_x, mag_x, sum;
        cur_x = {cur[c_dpw-1], cur};
        tgt_x = {tgt[c_dpw-1], tgt};
        mag_x = {2'b00, mag};
        sum   = up ? (cur_x + mag_x) : (cur_x - mag_x);
        if (up ? (sum >= tgt_x) : (sum <= tgt_x)) begin
            return tgt;
        end
        return sum[c_dpw-1:0];
    endfunction

    nco_dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_timer_load),
        .value_i (w_timer_value),
        .expire_o(w_expire)
    );

    always_comb begin
        w_state_next  = r_state;
        w_delta_next  = r_delta;
        w_step_next   = 1'b0;
        w_done_next   = 1'b0;
        w_accept      = 1'b0;
        w_reverse     = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_value = r_dwell;
        case (r_state)
            IDLE: begin
                if (cfg_valid_i && r_ready) begin
                    w_accept      = 1'b1;
                    w_state_next  = DWELL;
                    w_delta_next  = w_start_sat;
                    w_step_next   = 1'b1;
                    w_timer_load  = 1'b1;
                    w_timer_value = cfg_dwell_i;
                end
            end
            DWELL: begin
                if (abort_i) begin
                    w_state_next  = IDLE;
                    w_delta_next  = '0;
                    w_timer_load  = 1'b1;
                    w_timer_value = '0;
                end else if (w_expire) begin
                    if (r_delta != r_target) begin
                        w_delta_next = f_advance(r_delta, r_target, r_dir_up, r_step);
                        w_step_next  = 1'b1;
                        w_timer_load = 1'b1;
                    end else begin
                        case (r_mode)
                            SAWTOOTH: begin
                                w_delta_next = r_start;
                                w_step_next  = 1'b1;
                                w_timer_load = 1'b1;
                            end
                            TRIANGLE: begin
                                w_reverse    = 1'b1;
                                w_delta_next = f_advance(r_delta, w_rev_target, ~r_dir_up, r_step);
                                w_step_next  = 1'b1;
                                w_timer_load = 1'b1;
                            end
                            default: begin
                                w_state_next = DONE;
                                w_done_next  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
                if (abort_i) begin
                    w_delta_next = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_delta_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_delta       <= '0;
            r_ready       <= 1'b1;
            r_step_strobe <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_delta       <= w_delta_next;
            r_ready       <= (w_state_next == IDLE);
            r_step_strobe <= w_step_next;
            r_busy        <= (w_state_next != IDLE);
            r_done        <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start   <= '0;
            r_stop    <= '0;
            r_target  <= '0;
            r_step    <= c_step_one;
            r_dwell   <= '0;
            r_mode    <= SINGLE;
            r_dir_up  <= 1'b1;
            r_to_stop <= 1'b1;
        end else if (w_accept) begin
            r_start   <= w_start_sat;
            r_stop    <= w_stop_sat;
            r_target  <= w_stop_sat;
            r_step    <= w_step_eff;
            r_dwell   <= cfg_dwell_i;
            r_mode    <= decode_mode(cfg_mode_i);
            r_dir_up  <= (w_stop_sat >= w_start_sat);
            r_to_stop <= 1'b1;
        end else if (w_reverse) begin
            r_target  <= w_rev_target;
            r_dir_up  <= ~r_dir_up;
            r_to_stop <= ~r_to_stop;
        end
    end

    assign cfg_ready_o   = r_ready;
    assign delta_phase_o = r_delta;
    assign step_o        = r_step_strobe;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep scheduler for the NCO: accepts a sweep descriptor over a valid/ready handshake and drives the NCO's signed `delta_phase_i` input with a stepped start→stop sequence, holding each value for a programmable dwell. It sits directly upstream of `nco` (sharing `DELTA_PHASE_WIDTH`) and replaces a static phase-error input when chirp, hop or triangle sweeps are needed.

## Interface
- `DELTA_PHASE_WIDTH`, 10, width of the signed delta-phase words (matches the NCO input).
- `DWELL_WIDTH`, 16, width of the dwell counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `cfg_valid_i`  in  1  descriptor valid.
- `cfg_ready_o`  out  1  controller can accept a descriptor.
- `cfg_start_i`  in  DELTA_PHASE_WIDTH, signed  first delta-phase value.
- `cfg_stop_i`  in  DELTA_PHASE_WIDTH, signed  last delta-phase value.
- `cfg_step_i`  in  DELTA_PHASE_WIDTH-1, unsigned  step magnitude.
- `cfg_dwell_i`  in  DWELL_WIDTH  hold each value for dwell+1 cycles.
- `cfg_mode_i`  in  2  0 SINGLE, 1 SAWTOOTH, 2 TRIANGLE, 3 reserved (treated as SINGLE).
- `abort_i`  in  1  stop the sweep immediately.
- `delta_phase_o`  out  DELTA_PHASE_WIDTH, signed  drives the NCO's `delta_phase_i`.
- `step_o`  out  1  one-cycle strobe whenever `delta_phase_o` is loaded.
- `busy_o`  out  1  sweep in progress.
- `done_o`  out  1  one-cycle pulse when a SINGLE sweep completes.

## Operation
- States: IDLE, DWELL, DONE.
- IDLE:
  - `cfg_ready_o`=1.
  - When `cfg_valid_i`&&`cfg_ready_o`:
    - Latch the descriptor.
    - Load `delta_phase_o` with start.
    - Load the dwell counter with dwell.
    - Set direction up if stop ≥ start, otherwise down.
    - Assert `step_o` and go to DWELL.
- DWELL:
  - The counter decrements each cycle.
  - At 0, advance:
    - If `delta_phase_o`≠target: next = current ± step, clamped to target (never overshoots). Assert `step_o` and reload the counter.
    - If equal to target, apply end-of-leg by mode:
      - SINGLE: go to DONE.
      - SAWTOOTH: reload start (`step_o`), target stays stop.
      - TRIANGLE: reverse direction and swap target between stop and start, then take the first step toward the new target in the same cycle.
- DONE: `done_o`=1 for one cycle, `delta_phase_o` holds stop, then IDLE.
- `busy_o`=1 in DWELL and DONE.
- Arithmetic:
  - Use a DELTA_PHASE_WIDTH+1-bit signed intermediate.
  - Inputs equal to −2^(W−1) are saturated to −(2^(W−1)−1) at latch time, so the NCO's ±max range is never violated.
  - Step 0 is treated as 1.
- start==stop:
  - SINGLE holds for dwell+1 cycles, then DONE.
  - SAWTOOTH/TRIANGLE hold that value indefinitely, with `step_o` at each dwell expiry.
- `abort_i` in DWELL/DONE:
  - Has priority over advance and done.
  - Next cycle: IDLE, `delta_phase_o`=0, `done_o` not asserted, no `step_o`.
  - Ignored in IDLE.
- `cfg_valid_i` while busy: not accepted (`cfg_ready_o`=0); the descriptor is not latched.

## Timing
- All outputs are registered.
- Reset values: `delta_phase_o`=0, `cfg_ready_o`=1, `step_o`=0, `busy_o`=0, `done_o`=0; state IDLE; counter 0.
- Handshake accepted at edge t:
  - `delta_phase_o`=start from t+1 to t+1+dwell.
  - Next value at t+2+dwell.
  - `step_o` high in each cycle a new value first appears.
- SINGLE end: the last value is held dwell+1 cycles; `done_o` follows in the next cycle; `cfg_ready_o`=1 the cycle after.
- Asynchronous reset mid-sweep: outputs go to reset values immediately; the descriptor is discarded.

## Structure
- Package `nco_pkg`:
  - `sweep_mode_t` enum (SINGLE, SAWTOOTH, TRIANGLE).
  - `sweep_state_t` enum (IDLE, DWELL, DONE).
  - Saturation-limit constant derived from DELTA_PHASE_WIDTH.
- Sub-module `nco_dwell_timer`:
  - Loadable down-counter with `load_i`, `value_i`, `expire_o`.
  - Natural split; the controller instantiates one.
- Next-value/clamp logic stays in the controller.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-cycle → all outputs at reset values asynchronously; after release `cfg_ready_o`=1, `delta_phase_o`=0.
- SINGLE up: start 0, stop 10, step 4, dwell 2, accept at cycle 0 → `delta_phase_o`:
  - 0 on cycles 1–3, 4 on 4–6, 8 on 7–9, 10 on 10–12.
  - `done_o` on 13, `cfg_ready_o` on 14.
  - Four `step_o` pulses.
- TRIANGLE down/up: start 5, stop −5, step 5, dwell 0 → sequence 5, 0, −5, 0, 5, 0, −5 …; `done_o` never asserted.
- SAWTOOTH with saturation: start −512, stop −500, step 8, dwell 1 → −511, −503, −500, −511 …; each value held 2 cycles.
- Abort: assert `abort_i` in DWELL of a SAWTOOTH sweep at cycle k → at k+1 `delta_phase_o`=0, `busy_o`=0, `cfg_ready_o`=1, no `done_o`; a new descriptor is accepted at k+1.
- Busy backpressure: hold `cfg_valid_i`=1 with a different descriptor during a sweep → not latched; it is accepted in the first IDLE cycle after `done_o`.
